// File: rtl/valid_shift_register_if.sv
`default_nettype none
// ============================================================================
// Module      : valid_shift_register_if
// Description : Stream bundle for valid_shift_register. The master side feeds
//               the delay line and observes its output and occupancy; the
//               slave side is the delay line itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface valid_shift_register_if #(
    parameter int NPIPE_DEPTH  = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 2
);
    localparam int c_occ_width = $clog2(NPIPE_DEPTH + 1);
    localparam int c_bus_width = NUM_CHANNELS * DATA_WIDTH;

    logic                   enable;
    logic                   flush;
    logic                   input_valid;
    logic [c_bus_width-1:0] input_data;
    logic                   output_valid;
    logic [c_bus_width-1:0] output_data;
    logic [c_occ_width-1:0] occupancy;
    logic                   empty;

    modport master (
        output enable,
        output flush,
        output input_valid,
        output input_data,
        input  output_valid,
        input  output_data,
        input  occupancy,
        input  empty
    );

    modport slave (
        input  enable,
        input  flush,
        input  input_valid,
        input  input_data,
        output output_valid,
        output output_data,
        output occupancy,
        output empty
    );
endinterface
`default_nettype wire

// File: rtl/valid_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : valid_shift_register
// Description : Multi-lane stallable, flushable delay line with a shared valid
//               bit and a registered stage-occupancy count.
//               Optional macro SHIFT_REG_DATA_RESET_EN: reset/flush also zero
//               every stage's data registers.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_shift_register #(
    parameter int NPIPE_DEPTH  = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 2
) (
    input  wire logic             clock,
    input  wire logic             reset,
    valid_shift_register_if.slave bus
);
    localparam int c_occ_width = $clog2(NPIPE_DEPTH + 1);
    localparam int c_bus_width = NUM_CHANNELS * DATA_WIDTH;

    logic [NPIPE_DEPTH-1:0] r_valid;
    logic [c_bus_width-1:0] r_data [NPIPE_DEPTH];
    logic [c_occ_width-1:0] r_occ;
    logic                   r_empty;

    logic                   w_advance;
    logic [c_occ_width-1:0] w_occ_next;

    // Flush outranks enable, so a flushing edge never shifts.
    assign w_advance = bus.enable & ~bus.flush;

    // The running count stays equal to the popcount of r_valid, so it cannot
    // underflow or exceed NPIPE_DEPTH.
    assign w_occ_next = r_occ
                      + c_occ_width'(bus.input_valid)
                      - c_occ_width'(r_valid[NPIPE_DEPTH-1]);

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            r_valid <= '0;
            r_occ   <= '0;
            r_empty <= 1'b1;
        end else if (bus.enable) begin
            r_valid[0] <= bus.input_valid;
            for (int i = 1; i < NPIPE_DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
            r_occ   <= w_occ_next;
            r_empty <= (w_occ_next == '0);
        end
    end

`ifdef SHIFT_REG_DATA_RESET_EN
    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            for (int i = 0; i < NPIPE_DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (bus.enable) begin
            r_data[0] <= bus.input_data;
            for (int i = 1; i < NPIPE_DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end
`else
    // No data reset; contents are qualified by r_valid. Reset and flush still
    // block loading so a dropped word never enters the pipe.
    always_ff @(posedge clock) begin
        if (w_advance && !reset) begin
            r_data[0] <= bus.input_data;
            for (int i = 1; i < NPIPE_DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end
`endif

    assign bus.output_valid = r_valid[NPIPE_DEPTH-1];
    assign bus.output_data  = r_data[NPIPE_DEPTH-1];
    assign bus.occupancy    = r_occ;
    assign bus.empty        = r_empty;

endmodule
`default_nettype wire
